cgra_cfg_wb_master: RTL and testbench
=====================================

Name: cgra_cfg_wb_master

Overview:
- Wishbone initiator that drives the CGRA configuration CSR responder.
- Converts one high-level config command (write or read of one CGRA config word) into the required sequence of Wishbone single accesses: address register, data register, write/read strobe, read-back.
- Sits between a config source (loader, test sequencer or debug port) and the CSR responder.
- Returns a one-cycle response with read data or a timeout error.

Parameters:
- WISHBONE_BASE_ADDR, 32'h30000000, base of the CSR map. Register offsets: +0x00 CFG_ADDR, +0x04 CFG_WDATA, +0x08 CFG_RDATA, +0x0C CFG_WRITE, +0x10 CFG_READ.
- READ_WAIT, 8, idle cycles between raising CFG_READ and reading CFG_RDATA (CGRA multicycle read path); range 0..255.
- TIMEOUT, 16, max cycles a single access waits for ack before abort; must be ≥ 2.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  synchronous active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_write  in  1  1 = config write, 0 = config read
- cmd_addr  in  32  CGRA config address
- cmd_data  in  32  CGRA config write data (ignored for reads)
- rsp_valid  out  1  one-cycle completion pulse
- rsp_data  out  32  read data (0 for writes and errors)
- rsp_err  out  1  timeout flag, qualified by rsp_valid
- wbm_cyc_o  out  1  Wishbone cycle
- wbm_stb_o  out  1  Wishbone strobe
- wbm_we_o  out  1  Wishbone write enable
- wbm_sel_o  out  4  byte select, always 4'hF during an access
- wbm_adr_o  out  32  Wishbone address
- wbm_dat_o  out  32  Wishbone write data
- wbm_dat_i  in  32  Wishbone read data
- wbm_ack_i  in  1  Wishbone acknowledge

Behaviour:
- Reset: all outputs 0 except cmd_ready. State goes to IDLE, step and counters cleared. cmd_ready is 1 in the first cycle after reset. Reset mid-sequence aborts at once: cyc/stb drop on that edge and no response is issued.
- Command acceptance: on cmd_valid & cmd_ready. cmd_write, cmd_addr and cmd_data are latched, and the inputs are don't-care afterwards.
- States: IDLE, ACCESS, GAP, RWAIT, DONE.
- Write sequence, three accesses in order, all with we=1:
  - adr=BASE+0x00, dat=addr
  - adr=BASE+0x04, dat=data
  - adr=BASE+0x0C, dat=1
- Read sequence, in order:
  - write adr=BASE+0x00, dat=addr
  - write adr=BASE+0x10, dat=1
  - RWAIT for READ_WAIT cycles
  - read adr=BASE+0x08 (we=0, dat_o=0), capturing wbm_dat_i on ack
  - write adr=BASE+0x10, dat=0
- ACCESS:
  - cyc=stb=1 and sel=4'hF; adr/dat/we held stable for the whole access.
  - On the edge sampling ack=1: drop cyc/stb, clear the timeout counter, advance the step. Go to GAP, or to DONE if it was the last step.
- GAP: exactly one cycle with cyc=stb=0, and wbm_ack_i is ignored. This absorbs the responder's trailing ack.
- RWAIT: counts READ_WAIT cycles with the bus idle (READ_WAIT=0 gives no extra cycle), then goes to ACCESS.
- Timeout:
  - Counter runs while in ACCESS without ack.
  - On reaching TIMEOUT cycles: drop cyc/stb and go to DONE with err=1.
  - Remaining steps are skipped, including the CFG_READ=0 cleanup.
- DONE: one cycle.
  - rsp_valid=1.
  - rsp_err = timeout flag.
  - rsp_data = captured read data for a successful read, else 0.
  - Next state is IDLE (cmd_ready=1). No back-to-back acceptance in DONE.
- Acks seen in IDLE, GAP, RWAIT or DONE are ignored.
- wbm_dat_i is sampled only when ack=1 during the read access.
- Zero-wait responder timing (cycle 1 = first stb cycle after the accept edge):
  - Write: stb in cycles 1, 4, 7; rsp_valid in cycle 9.
  - Read: stb in 1, 4, then RWAIT occupies 6..5+READ_WAIT, read stb at 6+READ_WAIT, last stb at 9+READ_WAIT, rsp_valid at 11+READ_WAIT.

Test Plan:
- Reset → cyc=stb=0, rsp_valid=0, cmd_ready=1; assert reset during the second write access → bus idle next cycle, no rsp_valid.
- Write cmd addr=0x0000_1234, data=0xDEAD_BEEF with the CSR responder attached → bus writes 0x30000000←0x1234, 0x30000004←0xDEADBEEF, 0x3000000C←1; responder emits a one-cycle config write pulse; rsp_valid in cycle 9, rsp_err=0, rsp_data=0.
- Read cmd addr=0x55, READ_WAIT=8, model returns 0xCAFE_F00D → writes 0x30000000←0x55 and 0x30000010←1, 8 idle cycles, read 0x30000008, then write 0x30000010←0; rsp_data=0xCAFEF00D at cycle 19.
- Responder inserts 3 wait states per access → sequence order unchanged; adr/dat stable during stalls; exactly one GAP cycle after each ack.
- Ack never asserted on access 2 → stb held 16 cycles then dropped, rsp_valid with rsp_err=1 and rsp_data=0; no third access issued.
- Spurious ack in IDLE and in GAP, and cmd_valid held high in DONE → no state change, command accepted only in the following IDLE cycle.

Source files
------------

// File: rtl/cgra_cfg_wb_master.sv
// Wishbone initiator that turns one CGRA config read/write command into the
// CSR responder's access sequence (address, data, strobe, read-back).
module cgra_cfg_wb_master #(
    parameter logic [31:0] WISHBONE_BASE_ADDR = 32'h3000_0000,
    parameter int          READ_WAIT          = 8,
    parameter int          TIMEOUT            = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i
);
    localparam int            TW      = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [7:0]    RW_LAST = 8'((READ_WAIT > 0) ? READ_WAIT - 1 : 0);

    typedef enum logic [2:0] {IDLE, ACCESS, GAP, RWAIT, DONE} state_t;

    state_t        state;
    logic          wr_q;
    logic [31:0]   addr_q, data_q, rdata_q;
    logic [2:0]    step;
    logic [TW-1:0] tcnt;
    logic [7:0]    wcnt;

    logic          src_wr;
    logic [2:0]    src_step;
    logic [31:0]   src_addr, src_data;
    logic          nxt_we;
    logic [31:0]   nxt_adr, nxt_dat;
    logic          last_step, rd_step, rw_step;

    // Access descriptor for the step about to be issued; in IDLE it comes
    // straight from the command inputs so the first strobe needs no extra cycle.
    always_comb begin
        src_wr   = (state == IDLE) ? cmd_write : wr_q;
        src_step = (state == IDLE) ? 3'd0 : step;
        src_addr = (state == IDLE) ? cmd_addr : addr_q;
        src_data = (state == IDLE) ? cmd_data : data_q;
        nxt_we   = 1'b1;
        nxt_adr  = WISHBONE_BASE_ADDR;
        nxt_dat  = src_addr;
        case (src_step)
            3'd1: begin
                nxt_adr = WISHBONE_BASE_ADDR + (src_wr ? 32'h04 : 32'h10);
                nxt_dat = src_wr ? src_data : 32'd1;
            end
            3'd2: begin
                nxt_adr = WISHBONE_BASE_ADDR + (src_wr ? 32'h0C : 32'h08);
                nxt_dat = src_wr ? 32'd1 : 32'd0;
                nxt_we  = src_wr;
            end
            3'd3: begin
                nxt_adr = WISHBONE_BASE_ADDR + 32'h10;
                nxt_dat = 32'd0;
            end
            default: ;
        endcase
    end

    assign last_step = wr_q ? (step == 3'd2) : (step == 3'd3);
    assign rd_step   = !wr_q && (step == 3'd2);
    assign rw_step   = !wr_q && (step == 3'd1);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= '0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            rdata_q   <= '0;
            step      <= '0;
            tcnt      <= '0;
            wcnt      <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            case (state)
                IDLE: if (cmd_valid) begin
                    wr_q      <= cmd_write;
                    addr_q    <= cmd_addr;
                    data_q    <= cmd_data;
                    rdata_q   <= '0;
                    step      <= '0;
                    tcnt      <= '0;
                    cmd_ready <= 1'b0;
                    wbm_cyc_o <= 1'b1;
                    wbm_stb_o <= 1'b1;
                    wbm_sel_o <= 4'hF;
                    wbm_we_o  <= nxt_we;
                    wbm_adr_o <= nxt_adr;
                    wbm_dat_o <= nxt_dat;
                    state     <= ACCESS;
                end
                ACCESS: begin
                    if (wbm_ack_i || tcnt == TO_LAST) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        wbm_we_o  <= 1'b0;
                        wbm_sel_o <= '0;
                        wbm_adr_o <= '0;
                        wbm_dat_o <= '0;
                        tcnt      <= '0;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                    if (wbm_ack_i) begin
                        if (rd_step) rdata_q <= wbm_dat_i;
                        if (last_step) begin
                            state     <= DONE;
                            rsp_valid <= 1'b1;
                            rsp_data  <= wr_q ? 32'd0 : rdata_q;
                        end else begin
                            step  <= step + 3'd1;
                            wcnt  <= '0;
                            // The read-wait window doubles as the post-ack idle cycle.
                            state <= (rw_step && READ_WAIT > 0) ? RWAIT : GAP;
                        end
                    end else if (tcnt == TO_LAST) begin
                        state     <= DONE;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                    end
                end
                GAP, RWAIT: begin
                    if (state == GAP || wcnt == RW_LAST) begin
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        wbm_sel_o <= 4'hF;
                        wbm_we_o  <= nxt_we;
                        wbm_adr_o <= nxt_adr;
                        wbm_dat_o <= nxt_dat;
                        state     <= ACCESS;
                    end else begin
                        wcnt <= wcnt + 8'd1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cgra_cfg_wb_master.sv
// Directed bench: CSR responder model with wait states / ack suppression, a
// transaction-level expectation queue, and a per-cycle compare process.
module tb_cgra_cfg_wb_master;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int RW = 8;

    logic        clk = 1'b0, rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_data;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_data;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;

    always #5 clk = ~clk;

    cgra_cfg_wb_master #(.WISHBONE_BASE_ADDR(BASE), .READ_WAIT(RW), .TIMEOUT(16)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i)
    );

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- CSR responder model ----------------
    int          ws = 0, kill_acc = -1, acc_n = 0, scnt = 0, wr_pulses = 0, cur_acc;
    logic        ack_r = 1'b0, spur = 1'b0, stb_d = 1'b0;
    logic [15:0] junk = 16'h0;
    logic [31:0] r_addr = '0, r_wdata = '0, pulse_addr = '0, pulse_data = '0;

    function automatic logic [31:0] rd_val(input logic [31:0] a);
        return (a == 32'h55) ? 32'hCAFE_F00D : (32'h1000_0000 | a);
    endfunction

    assign cur_acc   = stb_d ? acc_n : acc_n + 1;
    assign wbm_ack_i = ack_r | spur;
    assign wbm_dat_i = (ack_r && wbm_stb_o && !wbm_we_o && wbm_adr_o == BASE + 32'h08)
                       ? rd_val(r_addr) : {16'h5A5A, junk};

    always @(posedge clk) begin
        junk  <= junk + 16'd1;
        stb_d <= wbm_stb_o;
        if (wbm_cyc_o && wbm_stb_o) begin
            if (!stb_d) acc_n <= acc_n + 1;
            scnt  <= scnt + 1;
            ack_r <= (scnt >= ws) && (cur_acc != kill_acc);
            if (ack_r && wbm_we_o) begin
                if (wbm_adr_o == BASE) r_addr <= wbm_dat_o;
                if (wbm_adr_o == BASE + 32'h04) r_wdata <= wbm_dat_o;
                if (wbm_adr_o == BASE + 32'h0C && wbm_dat_o[0]) begin
                    wr_pulses  <= wr_pulses + 1;
                    pulse_addr <= r_addr;
                    pulse_data <= r_wdata;
                end
            end
        end else begin
            scnt  <= 0;
            ack_r <= 1'b0;
        end
    end

    // ---------------- transaction-level model ----------------
    typedef struct { logic [31:0] adr; logic [31:0] dat; logic we; int gap; } txn_t;
    typedef struct { logic [31:0] data; logic err; } rsp_t;
    txn_t exp_q[$];
    rsp_t rsp_q[$];

    task automatic push_txn(input logic [31:0] off, input logic [31:0] d, input logic we, input int gap);
        txn_t t;
        t.adr = BASE + off; t.dat = d; t.we = we; t.gap = gap;
        exp_q.push_back(t);
    endtask

    task automatic push_rsp(input logic [31:0] d, input logic e);
        rsp_t r;
        r.data = d; r.err = e;
        rsp_q.push_back(r);
    endtask

    task automatic model_write(input logic [31:0] a, input logic [31:0] d);
        push_txn(32'h00, a, 1'b1, -1);
        push_txn(32'h04, d, 1'b1, 1);
        push_txn(32'h0C, 32'd1, 1'b1, 1);
        push_rsp(32'd0, 1'b0);
    endtask

    task automatic model_read(input logic [31:0] a, input logic [31:0] rv);
        push_txn(32'h00, a, 1'b1, -1);
        push_txn(32'h10, 32'd1, 1'b1, 1);
        push_txn(32'h08, 32'd0, 1'b0, RW);
        push_txn(32'h10, 32'd0, 1'b1, 1);
        push_rsp(rv, 1'b0);
    endtask

    // ---------------- per-cycle compare ----------------
    int          idle_cnt = 0, run_len = 0, last_len = 0;
    logic        stb_prev = 1'b0, rsp_prev = 1'b0, we_prev = 1'b0;
    logic [31:0] adr_prev = '0, dat_prev = '0;

    always @(negedge clk) begin
        if (rst) begin
            stb_prev = 1'b0;
            rsp_prev = 1'b0;
            idle_cnt = 0;
        end else begin
            chk("cyc_eq_stb", wbm_cyc_o, wbm_stb_o);
            if (wbm_stb_o) begin
                chk("sel", wbm_sel_o, 4'hF);
                if (!stb_prev) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_access", 1, 0);
                    end else begin
                        txn_t t;
                        t = exp_q.pop_front();
                        chk("acc_adr", wbm_adr_o, t.adr);
                        chk("acc_dat", wbm_dat_o, t.dat);
                        chk("acc_we", wbm_we_o, t.we);
                        if (t.gap >= 0) chk("idle_gap", idle_cnt, t.gap);
                    end
                    run_len = 1;
                end else begin
                    chk("stable_adr", wbm_adr_o, adr_prev);
                    chk("stable_dat", wbm_dat_o, dat_prev);
                    chk("stable_we", wbm_we_o, we_prev);
                    run_len++;
                end
                idle_cnt = 0;
            end else begin
                if (stb_prev) last_len = run_len;
                idle_cnt++;
            end
            if (rsp_valid) begin
                chk("rsp_one_cycle", rsp_prev, 0);
                if (rsp_q.size() == 0) begin
                    chk("unexpected_rsp", 1, 0);
                end else begin
                    rsp_t r;
                    r = rsp_q.pop_front();
                    chk("rsp_data", rsp_data, r.data);
                    chk("rsp_err", rsp_err, r.err);
                end
            end
            stb_prev = wbm_stb_o;
            rsp_prev = rsp_valid;
            adr_prev = wbm_adr_o;
            dat_prev = wbm_dat_o;
            we_prev  = wbm_we_o;
        end
    end

    // ---------------- stimulus ----------------
    logic        hold_valid = 1'b0;
    logic [31:0] got_data;
    logic        got_err;

    // Called just after a negedge; returns the cycle (1 = first after accept) of rsp_valid.
    task automatic run_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d, output int n);
        n = -1;
        chk("ready_before_cmd", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_data = d;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            if (i == 1 && !hold_valid) begin
                cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = 32'hFFFF_FFFF; cmd_data = 32'h0;
            end
            if (rsp_valid) begin
                n = i; got_data = rsp_data; got_err = rsp_err;
                break;
            end
        end
        if (n < 0) chk("rsp_wait_expired", 1, 0);
    endtask

    task automatic wait_rsp(output int n);
        n = -1;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            if (rsp_valid) begin n = i; break; end
        end
        if (n < 0) chk("rsp_wait_expired", 1, 0);
    endtask

    initial begin
        int n, base_acc;
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_cyc", wbm_cyc_o, 0);
        chk("rst_stb", wbm_stb_o, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", cmd_ready, 1);

        // Zero-wait write
        model_write(32'h0000_1234, 32'hDEAD_BEEF);
        run_cmd(1'b1, 32'h0000_1234, 32'hDEAD_BEEF, n);
        chk("wr_latency", n, 9);
        chk("wr_rsp_data", got_data, 32'h0);
        chk("wr_rsp_err", got_err, 0);
        @(negedge clk);
        chk("wr_pulses", wr_pulses, 1);
        chk("pulse_addr", pulse_addr, 32'h0000_1234);
        chk("pulse_data", pulse_data, 32'hDEAD_BEEF);

        // Zero-wait read
        model_read(32'h55, 32'hCAFE_F00D);
        run_cmd(1'b0, 32'h55, 32'h1111_1111, n);
        chk("rd_latency", n, 19);
        chk("rd_rsp_data", got_data, 32'hCAFE_F00D);
        chk("rd_rsp_err", got_err, 0);
        @(negedge clk);

        // Three wait states per access
        ws = 3;
        model_write(32'h77, 32'h0BAD_F00D);
        run_cmd(1'b1, 32'h77, 32'h0BAD_F00D, n);
        chk("ws_wr_latency", n, 18);
        @(negedge clk);
        chk("ws_pulse_data", pulse_data, 32'h0BAD_F00D);
        model_read(32'h99, 32'h1000_0099);
        run_cmd(1'b0, 32'h99, 32'h0, n);
        chk("ws_rd_data", got_data, 32'h1000_0099);
        @(negedge clk);
        ws = 0;

        // No ack on the second access
        base_acc = acc_n;
        kill_acc = acc_n + 2;
        push_txn(32'h00, 32'h2222, 1'b1, -1);
        push_txn(32'h04, 32'h3333, 1'b1, 1);
        push_rsp(32'h0, 1'b1);
        run_cmd(1'b1, 32'h2222, 32'h3333, n);
        chk("to_latency", n, 20);
        chk("to_rsp_err", got_err, 1);
        chk("to_rsp_data", got_data, 32'h0);
        repeat (3) @(negedge clk);
        chk("to_stb_len", last_len, 16);
        chk("to_access_count", acc_n - base_acc, 2);
        chk("to_no_pulse", wr_pulses, 2);
        kill_acc = -1;

        // Spurious ack in IDLE
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        chk("spur_idle_stb", wbm_stb_o, 0);
        chk("spur_idle_ready", cmd_ready, 1);
        @(negedge clk);

        // cmd_valid held through DONE, plus an ack during DONE
        hold_valid = 1'b1;
        model_write(32'h44, 32'h4444);
        model_write(32'h44, 32'h4444);
        run_cmd(1'b1, 32'h44, 32'h4444, n);
        chk("hold_latency", n, 9);
        chk("done_ready", cmd_ready, 0);
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        chk("post_done_ready", cmd_ready, 1);
        chk("post_done_stb", wbm_stb_o, 0);
        @(negedge clk);
        cmd_valid = 1'b0;
        hold_valid = 1'b0;
        chk("reaccept_stb", wbm_stb_o, 1);
        wait_rsp(n);
        chk("reaccept_latency", n, 8);
        @(negedge clk);
        chk("total_pulses", wr_pulses, 4);

        // Reset during the second write access
        push_txn(32'h00, 32'h6666, 1'b1, -1);
        push_txn(32'h04, 32'h7777, 1'b1, 1);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h6666; cmd_data = 32'h7777;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_stb", wbm_stb_o, 1);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("midrst_cyc", wbm_cyc_o, 0);
        chk("midrst_stb", wbm_stb_o, 0);
        chk("midrst_rsp", rsp_valid, 0);
        chk("midrst_ready", cmd_ready, 1);
        #1 rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("midrst_no_pulse", wr_pulses, 4);
        chk("exp_q_empty", exp_q.size(), 0);
        chk("rsp_q_empty", rsp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
